// File: rtl/nfa_chain_engine.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : nfa_chain_engine                                               |
// | Purpose  : Literal-chain NFA matcher over a pre-decoded char-class bus,    |
// |            with optional self-loops, anchoring, sticky/pulse match,       |
// |            saturating match counter and first-match byte offset.          |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module nfa_chain_engine #(
  parameter int                            CLASS_W   = 8,
  parameter int                            STATE_CNT = 4,
  parameter int                            IDX_W     = 3,
  parameter logic [STATE_CNT*IDX_W-1:0]    CLASS_SEL = {3'd3, 3'd2, 3'd1, 3'd0},
  parameter logic [STATE_CNT-1:0]          LOOP_MASK = 4'b0100,
  parameter bit                            ANCHORED  = 1'b0,
  parameter bit                            STICKY    = 1'b1,
  parameter int                            CNT_W     = 8,
  parameter int                            OFF_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sod,
  input  logic               en,
  input  logic [CLASS_W-1:0] cls_in,
  output logic               match,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [OFF_W-1:0]   match_off,
  output logic               off_valid,
  output logic               busy
);

  logic [STATE_CNT:1] r_state;
  logic [STATE_CNT:1] w_state_nxt;
  logic [STATE_CNT:1] w_cls;
  logic               r_first;
  logic [OFF_W-1:0]   r_pos;
  logic               r_match_pulse;
  logic               r_match;
  logic [CNT_W-1:0]   r_match_cnt;
  logic [OFF_W-1:0]   r_match_off;
  logic               r_off_valid;
  logic               w_start;
  logic               w_hit;

  assign w_start = ANCHORED ? r_first : 1'b1;

  generate
    for (genvar gi = 1; gi <= STATE_CNT; gi++) begin : g_state
      localparam int c_idx = int'(CLASS_SEL[(gi-1)*IDX_W +: IDX_W]);

      // Out-of-range class indices tie the state off permanently.
      if (c_idx < CLASS_W) begin : g_cls_in
        assign w_cls[gi] = cls_in[c_idx];
      end else begin : g_cls_off
        assign w_cls[gi] = 1'b0;
      end

      if (gi == 1) begin : g_head
        assign w_state_nxt[gi] = w_cls[gi] & (w_start | (LOOP_MASK[gi-1] & r_state[gi]));
      end else begin : g_link
        assign w_state_nxt[gi] = w_cls[gi] & (r_state[gi-1] | (LOOP_MASK[gi-1] & r_state[gi]));
      end
    end
  endgenerate

  assign w_hit = w_state_nxt[STATE_CNT];

  // Reset leaves first pending so anchored rules can fire on the first byte afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= '0;
      r_first       <= 1'b1;
      r_pos         <= '0;
      r_match_pulse <= 1'b0;
      r_match       <= 1'b0;
      r_match_cnt   <= '0;
      r_match_off   <= '0;
      r_off_valid   <= 1'b0;
    end else if (sod) begin
      r_state       <= '0;
      r_first       <= 1'b1;
      r_pos         <= '0;
      r_match_pulse <= 1'b0;
      r_match       <= 1'b0;
      r_match_cnt   <= '0;
      r_match_off   <= '0;
      r_off_valid   <= 1'b0;
    end else if (en) begin
      r_state       <= w_state_nxt;
      r_first       <= 1'b0;
      r_match_pulse <= w_hit;
      r_match       <= r_match | w_hit;
      if (w_hit && (r_match_cnt != {CNT_W{1'b1}})) begin
        r_match_cnt <= r_match_cnt + 1'b1;
      end
      if (w_hit && !r_off_valid) begin
        r_match_off <= r_pos;
        r_off_valid <= 1'b1;
      end
      if (r_pos != {OFF_W{1'b1}}) begin
        r_pos <= r_pos + 1'b1;
      end
    end else begin
      r_match_pulse <= 1'b0;
    end
  end

  generate
    if (STICKY) begin : g_sticky
      assign match = r_match;
    end else begin : g_pulse
      assign match = r_match_pulse;
    end
  endgenerate

  assign match_pulse = r_match_pulse;
  assign match_cnt   = r_match_cnt;
  assign match_off   = r_match_off;
  assign off_valid   = r_off_valid;
  assign busy        = |r_state;

endmodule
`default_nettype wire

// File: tb/tb_nfa_chain_engine.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_nfa_chain_engine                                            |
// | Purpose  : Directed scoreboard bench for three engine configurations:      |
// |            free (0), anchored (1), pulse-mode (2).                        |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module tb_nfa_chain_engine;

  logic       clk;
  logic       rst_n;
  logic       sod;
  logic       en;
  logic [7:0] cls_in;

  logic [2:0] w_match;
  logic [2:0] w_pulse;
  logic [7:0] w_cnt [3];
  logic [15:0] w_off [3];
  logic [2:0] w_ov;
  logic [2:0] w_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit pulse;
    bit match;
    int cnt;
    int off;
    bit ov;
    bit busy;
  } exp_t;

  exp_t sb_q[$];

  // Abstract model of the default "a b space+ c" chain for each configuration.
  bit m_s     [3][4];
  bit m_first [3];
  bit m_pulse [3];
  bit m_match [3];
  int m_cnt   [3];
  int m_pos   [3];
  int m_off   [3];
  bit m_ov    [3];

  nfa_chain_engine #(.ANCHORED(1'b0), .STICKY(1'b1)) u_free (
    .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .cls_in(cls_in),
    .match(w_match[0]), .match_pulse(w_pulse[0]), .match_cnt(w_cnt[0]),
    .match_off(w_off[0]), .off_valid(w_ov[0]), .busy(w_busy[0])
  );

  nfa_chain_engine #(.ANCHORED(1'b1), .STICKY(1'b1)) u_anch (
    .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .cls_in(cls_in),
    .match(w_match[1]), .match_pulse(w_pulse[1]), .match_cnt(w_cnt[1]),
    .match_off(w_off[1]), .off_valid(w_ov[1]), .busy(w_busy[1])
  );

  nfa_chain_engine #(.ANCHORED(1'b0), .STICKY(1'b0)) u_pulse (
    .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .cls_in(cls_in),
    .match(w_match[2]), .match_pulse(w_pulse[2]), .match_cnt(w_cnt[2]),
    .match_off(w_off[2]), .off_valid(w_ov[2]), .busy(w_busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input byte c);
    case (c)
      "a":     return 8'b0000_0001;
      "b":     return 8'b0000_0010;
      " ":     return 8'b0000_0100;
      "c":     return 8'b0000_1000;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic cmp(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int k);
    for (int i = 0; i < 4; i++) m_s[k][i] = 1'b0;
    m_first[k] = 1'b1;
    m_pulse[k] = 1'b0;
    m_match[k] = 1'b0;
    m_cnt[k]   = 0;
    m_pos[k]   = 0;
    m_off[k]   = 0;
    m_ov[k]    = 1'b0;
  endtask

  task automatic model_step(input int k, input bit s, input bit e, input logic [7:0] c);
    bit ns [4];
    bit start;
    bit hit;
    if (s) begin
      model_clear(k);
    end else if (e) begin
      start = (k == 1) ? m_first[k] : 1'b1;
      ns[0] = c[0] & start;
      ns[1] = c[1] & m_s[k][0];
      ns[2] = c[2] & (m_s[k][1] | m_s[k][2]);
      ns[3] = c[3] & m_s[k][2];
      hit = ns[3];
      for (int i = 0; i < 4; i++) m_s[k][i] = ns[i];
      m_first[k] = 1'b0;
      m_pulse[k] = hit;
      m_match[k] = (k == 2) ? hit : (m_match[k] | hit);
      if (hit && m_cnt[k] < 255) m_cnt[k]++;
      if (hit && !m_ov[k]) begin
        m_off[k] = m_pos[k];
        m_ov[k]  = 1'b1;
      end
      if (m_pos[k] < 65535) m_pos[k]++;
    end else begin
      m_pulse[k] = 1'b0;
      if (k == 2) m_match[k] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    exp_t ex;
    for (int k = 0; k < 3; k++) begin
      ex = sb_q.pop_front();
      cmp($sformatf("pulse[%0d]", k), int'(w_pulse[k]), int'(ex.pulse));
      cmp($sformatf("match[%0d]", k), int'(w_match[k]), int'(ex.match));
      cmp($sformatf("cnt[%0d]", k),   int'(w_cnt[k]),   ex.cnt);
      cmp($sformatf("off[%0d]", k),   int'(w_off[k]),   ex.off);
      cmp($sformatf("ov[%0d]", k),    int'(w_ov[k]),    int'(ex.ov));
      cmp($sformatf("busy[%0d]", k),  int'(w_busy[k]),  int'(ex.busy));
    end
  endtask

  task automatic step(input bit s, input bit e, input logic [7:0] c);
    exp_t ex;
    @(negedge clk);
    sod = s; en = e; cls_in = c;
    for (int k = 0; k < 3; k++) begin
      model_step(k, s, e, c);
      ex.pulse = m_pulse[k];
      ex.match = m_match[k];
      ex.cnt   = m_cnt[k];
      ex.off   = m_off[k];
      ex.ov    = m_ov[k];
      ex.busy  = m_s[k][0] | m_s[k][1] | m_s[k][2] | m_s[k][3];
      sb_q.push_back(ex);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send(input string str);
    for (int i = 0; i < str.len(); i++) step(1'b0, 1'b1, enc(str[i]));
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("%s_match[%0d]", tag, k), int'(w_match[k]), 0);
      cmp($sformatf("%s_pulse[%0d]", tag, k), int'(w_pulse[k]), 0);
      cmp($sformatf("%s_cnt[%0d]", tag, k),   int'(w_cnt[k]),   0);
      cmp($sformatf("%s_off[%0d]", tag, k),   int'(w_off[k]),   0);
      cmp($sformatf("%s_ov[%0d]", tag, k),    int'(w_ov[k]),    0);
      cmp($sformatf("%s_busy[%0d]", tag, k),  int'(w_busy[k]),  0);
    end
  endtask

  initial begin
    rst_n = 1'b0; sod = 1'b0; en = 1'b0; cls_in = '0;
    for (int k = 0; k < 3; k++) model_clear(k);
    #12;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // 1: basic match with latency and sticky hold
    step(1'b1, 1'b0, 8'h00);
    send("ab ");
    cmp("t1_pre_pulse", int'(w_pulse[0]), 0);
    send("c");
    cmp("t1_pulse", int'(w_pulse[0]), 1);
    cmp("t1_cnt",   int'(w_cnt[0]),   1);
    cmp("t1_off",   int'(w_off[0]),   3);
    cmp("t1_ov",    int'(w_ov[0]),    1);
    step(1'b0, 1'b0, 8'h00);
    cmp("t1_hold_match", int'(w_match[0]), 1);
    cmp("t1_hold_pulse", int'(w_pulse[0]), 0);

    // 2: looped space state, and a missing space
    step(1'b1, 1'b0, 8'h00);
    send("ab   c");
    cmp("t2_off", int'(w_off[0]), 5);
    cmp("t2_cnt", int'(w_cnt[0]), 1);
    step(1'b1, 1'b0, 8'h00);
    send("abc");
    cmp("t2_nomatch_cnt", int'(w_cnt[0]), 0);
    cmp("t2_nomatch_ov",  int'(w_ov[0]),  0);

    // 3: unanchored vs anchored with a leading junk byte
    step(1'b1, 1'b0, 8'h00);
    send("xab c");
    cmp("t3_free_off",   int'(w_off[0]),   4);
    cmp("t3_free_match", int'(w_match[0]), 1);
    cmp("t3_anch_match", int'(w_match[1]), 0);
    cmp("t3_anch_cnt",   int'(w_cnt[1]),   0);

    // 4: counter saturation; pulse-mode match tracks the pulse
    step(1'b1, 1'b0, 8'h00);
    for (int r = 0; r < 300; r++) send("ab c");
    cmp("t4_cnt_sat",  int'(w_cnt[0]), 255);
    cmp("t4_off",      int'(w_off[0]), 3);
    cmp("t4_anch_cnt", int'(w_cnt[1]), 1);
    cmp("t4_pls_match", int'(w_match[2]), 1);
    step(1'b0, 1'b0, 8'h00);
    cmp("t4_pls_drop", int'(w_match[2]), 0);
    cmp("t4_sticky_hold", int'(w_match[0]), 1);

    // 5: idle gaps inside the stream; sod wins over en
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, enc("a"));
    step(1'b0, 1'b0, enc("c"));
    step(1'b0, 1'b1, enc("b"));
    step(1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, enc(" "));
    step(1'b0, 1'b0, enc("a"));
    step(1'b0, 1'b1, enc("c"));
    cmp("t5_off", int'(w_off[0]), 3);
    cmp("t5_cnt", int'(w_cnt[0]), 1);
    step(1'b1, 1'b1, enc("a"));
    check_all_zero("t5_sod");

    // 6: asynchronous reset mid-stream discards the partial match
    step(1'b1, 1'b0, 8'h00);
    send("ab ");
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    for (int k = 0; k < 3; k++) model_clear(k);
    @(negedge clk); rst_n = 1'b1;
    send("c");
    cmp("t6_c_nomatch", int'(w_match[0]), 0);
    send("ab c");
    cmp("t6_off",  int'(w_off[0]), 4);
    cmp("t6_cnt",  int'(w_cnt[0]), 1);
    cmp("t6_anch", int'(w_match[1]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
